// File: rtl/rca_seq_ctrl.sv
// Sequencing wrapper around an external combinational ripple-carry adder: registers operands,
// waits a fixed settle time, captures sum/flags and hands the result downstream with valid/ready.
module rca_seq_ctrl #(
  parameter int unsigned W             = 64,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  input  logic         in_acc_en,
  input  logic         acc_clr,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero,
  output logic [W-1:0] acc_q
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [7:0] CntInit = 8'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         in_ready_q, in_ready_d;
  logic         acc_en_q, acc_en_d;
  logic [W-1:0] add_a_q, add_a_d;
  logic [W-1:0] add_b_q, add_b_d;
  logic         add_cin_q, add_cin_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_sum_q, out_sum_d;
  logic         out_cout_q, out_cout_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_zero_q, out_zero_d;
  logic [W-1:0] acc_d;
  logic [W-1:0] b_eff;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    acc_en_d    = acc_en_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    acc_d       = acc_q;
    b_eff       = in_acc_en ? acc_q : in_b;

    unique case (state_q)
      StIdle: begin
        if (!in_ready_q) begin
          // first cycle out of reset: only raise ready
          in_ready_d = 1'b1;
        end else if (in_valid) begin
          add_a_d    = in_a;
          add_b_d    = in_op ? ~b_eff : b_eff;
          add_cin_d  = in_op;
          acc_en_d   = in_acc_en;
          cnt_d      = CntInit;
          in_ready_d = 1'b0;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          out_sum_d   = add_sum;
          out_cout_d  = add_cout;
          out_zero_d  = (add_sum == '0);
          out_ovf_d   = (add_a_q[W-1] == add_b_q[W-1]) && (add_sum[W-1] != add_a_q[W-1]);
          out_valid_d = 1'b1;
          if (acc_en_q) acc_d = add_sum;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // clear has priority over an accumulate capture on the same edge
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      acc_en_q    <= acc_en_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: directed vector table, hand-written accumulate/reset sequences and
// random operations checked against an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int W = 64;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_op, in_acc_en, acc_clr;
  logic [W-1:0] in_a, in_b, add_a, add_b, add_sum, out_sum, acc_q;
  logic         add_cin, add_cout, out_valid, out_ready, out_cout, out_ovf, out_zero;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] acc_m = '0;

  rca_seq_ctrl #(.W(W), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc_en (in_acc_en),
    .acc_clr   (acc_clr),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .acc_q     (acc_q)
  );

  // Stand-in for the combinational adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           rdy;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on the requested operation
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                 output logic [W-1:0] s, output logic c, output logic v,
                                 output logic z);
    logic [W:0] wide;
    if (op) begin
      s = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s = wide[W-1:0];
      c = wide[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    z = (s == '0);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic acc_en, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf, input logic e_zero, input int rdy_wait,
                        input bit clr_cap, input string tag);
    logic [W-1:0] beff, e_acc;
    int n, lat;
    beff  = acc_en ? acc_m : b;
    e_acc = clr_cap ? '0 : (acc_en ? e_sum : acc_m);
    in_a = a; in_b = b; in_op = op; in_acc_en = acc_en; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op;
    chk({tag, " add_a"}, add_a, a);
    chk({tag, " add_b"}, add_b, op ? ~beff : beff);
    chk({tag, " add_cin"}, {63'd0, add_cin}, {63'd0, op});
    chk({tag, " in_ready_busy"}, {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      acc_clr = clr_cap && (lat == S - 1);
    end
    acc_clr = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(S));
    chk({tag, " out_sum"}, out_sum, e_sum);
    chk({tag, " out_cout"}, {63'd0, out_cout}, {63'd0, e_cout});
    chk({tag, " out_ovf"}, {63'd0, out_ovf}, {63'd0, e_ovf});
    chk({tag, " out_zero"}, {63'd0, out_zero}, {63'd0, e_zero});
    chk({tag, " acc_q"}, acc_q, e_acc);
    for (int i = 0; i < rdy_wait; i++) begin
      in_valid = i[0];
      in_a = {$urandom, $urandom};
      @(negedge clk);
      chk({tag, " bp out_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, " bp in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, " bp out_sum"}, out_sum, e_sum);
      chk({tag, " bp add_a"}, add_a, a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " done out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " done in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, " retain out_sum"}, out_sum, e_sum);
    acc_m = e_acc;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    acc_m = '0;
    chk("acc_clr", acc_q, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] a, b, beff, s;
    logic c, v, z, op, ae;
    bit seen;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 0};
    vecs[1] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
                1'b0, 10};
    vecs[3] = '{64'd7, 64'd7, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 2};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                1'b0, 1};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1,
                1'b1, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_acc_en = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst add_a", add_a, 64'd0);
    chk("rst add_b", add_b, 64'd0);
    chk("rst flags", {60'd0, add_cin, out_cout, out_ovf, out_zero}, 64'd0);
    chk("rst out_sum", out_sum, 64'd0);
    chk("rst acc_q", acc_q, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel in_ready_pre", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("rel in_ready", {63'd0, in_ready}, 64'd1);
    chk("rel out_valid", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             vecs[i].zero, vecs[i].rdy, 1'b0, $sformatf("vec%0d", i));

    // Accumulate chain, then clear coinciding with the capture edge
    clear_acc();
    run_op(64'd10, 64'hDEAD, 1'b0, 1'b1, 64'd10, 1'b0, 1'b0, 1'b0, 0, 1'b0, "acc1");
    run_op(64'd20, 64'hBEEF, 1'b0, 1'b1, 64'd30, 1'b0, 1'b0, 1'b0, 0, 1'b0, "acc2");
    run_op(64'd30, 64'h1234, 1'b0, 1'b1, 64'd60, 1'b0, 1'b0, 1'b0, 0, 1'b0, "acc3");
    run_op(64'd5, 64'h0, 1'b0, 1'b1, 64'd65, 1'b0, 1'b0, 1'b0, 0, 1'b1, "acc_clr_cap");
    run_op(64'd77, 64'h0, 1'b0, 1'b1, 64'd77, 1'b0, 1'b0, 1'b0, 0, 1'b0, "acc_load");

    // Reset two cycles into SETTLE
    in_a = 64'd123; in_b = 64'd456; in_op = 1'b0; in_acc_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid add_a", add_a, 64'd123);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst add_a", add_a, 64'd0);
    chk("mid rst acc_q", acc_q, 64'd0);
    chk("mid rst ready_valid", {62'd0, in_ready, out_valid}, 64'd0);
    acc_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("mid no out_valid", {63'd0, seen}, 64'd0);
    run_op(64'd100, 64'd23, 1'b1, 1'b0, 64'd77, 1'b1, 1'b0, 1'b0, 0, 1'b0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      a = pick(); b = pick();
      op = 1'($urandom_range(0, 1));
      ae = ($urandom_range(0, 3) == 0);
      beff = ae ? acc_m : b;
      ref_op(a, beff, op, s, c, v, z);
      run_op(a, b, op, ae, s, c, v, z, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", i));
      if ($urandom_range(0, 5) == 0) clear_acc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
